// File: rtl/olivia_imem_loader.sv
// Byte-stream program loader: length-prefixed stream packed big-endian into 32-bit
// instruction words. Define OLIVIA_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module olivia_imem_loader #(
  parameter int unsigned DEPTH_WORDS = 16,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS + 1);

  // Handshake: a byte moves on a CLK edge where byte_valid and byte_ready are both 1;
  // the source must hold byte_data stable while byte_valid=1 and byte_ready=0.
  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
`ifdef OLIVIA_LOADER_CSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, len_q, len_d;
  logic [IDX_W-1:0]   idx_nxt;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        word_q, word_d;
  logic               byte_ready_q, byte_ready_d;
  logic               im_we_q, im_we_d;
  logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               fire;
`ifdef OLIVIA_LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign fire    = byte_valid & byte_ready_q;
  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
`ifdef OLIVIA_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_LEN: begin
        if (fire) begin
          if (byte_data != 8'd0 && 32'(byte_data) <= DEPTH_WORDS) begin
            state_d = S_DATA;
            len_d   = IDX_W'(byte_data);
            idx_d   = '0;
            bcnt_d  = 2'd0;
`ifdef OLIVIA_LOADER_CSUM_EN
            csum_d  = 8'd0;
`endif
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d = {word_q[15:0], byte_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef OLIVIA_LOADER_CSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          // The fourth byte completes the word; present it on the write port next cycle.
          if (bcnt_q == 2'd3) begin
            state_d    = S_WRITE;
            im_wdata_d = {word_q, byte_data};
            im_addr_d  = ADDR_W'({idx_q, 2'b00});
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_nxt;
        if (idx_nxt == len_q) begin
`ifdef OLIVIA_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef OLIVIA_LOADER_CSUM_EN
      S_CSUM: begin
        if (fire) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (reload) state_d = S_LEN;
      end
      default: state_d = S_ERR;
    endcase

    // Outputs are registered copies of what the next state implies.
`ifdef OLIVIA_LOADER_CSUM_EN
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
`else
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`endif
    im_we_d   = (state_d == S_WRITE);
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_LEN;
      idx_q        <= '0;
      len_q        <= '0;
      bcnt_q       <= 2'd0;
      word_q       <= 24'd0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= 32'd0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef OLIVIA_LOADER_CSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef OLIVIA_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_olivia_imem_loader.sv
// Directed bench for olivia_imem_loader; covers both the checksum and no-checksum builds
// (OLIVIA_LOADER_CSUM_EN) with a write scoreboard and a table of load scenarios.
module tb_olivia_imem_loader;
  localparam int AW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          reload = 1'b0;
  logic          byte_ready, im_we, cpu_rst, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [2:0]    dbg_state;

  olivia_imem_loader #(.DEPTH_WORDS(16), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [AW+31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write scoreboard: every im_we pulse must match the next expected {addr, data}.
  always @(negedge CLK) begin : write_mon
    logic [AW+31:0] e;
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(im_addr), 32'(e[AW+31:32]));
        check("write_data", im_wdata, e[31:0]);
      end
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (1) begin
      @(negedge CLK);
      if (byte_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got byte_ready 0 for %0d cycles expected 1", n);
        break;
      end
    end
    @(posedge CLK);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    byte_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 8) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("end_reached", 32'(done | err), 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge CLK);
    #1;
    reload = 1'b0;
    check("reload_done", 32'(done), 32'd0);
    check("reload_err", 32'(err), 32'd0);
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_ready", 32'(byte_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_im_we"}, 32'(im_we), 32'd0);
    check({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    check({tag, "_im_wdata"}, im_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Bytes and words are right-aligned: byte i of nb is bytes[8*(nb-1-i) +: 8].
  typedef struct {
    int          nb;
    logic [95:0] bytes;
    logic        exp_done;
    logic        exp_err;
    int          nw;
    logic [63:0] words;
  } vec_t;

  vec_t vecs[6];

  initial begin
`ifdef OLIVIA_LOADER_CSUM_EN
    vecs[0] = '{6,  96'h018B020020A9,         1'b1, 1'b0, 1, 64'h8B020020};
    vecs[1] = '{10, 96'h028B020020CB03004120, 1'b1, 1'b0, 2, 64'h8B020020CB030041};
    vecs[4] = '{6,  96'h018B02002000,         1'b0, 1'b1, 1, 64'h8B020020};
`else
    vecs[0] = '{5,  96'h018B020020,           1'b1, 1'b0, 1, 64'h8B020020};
    vecs[1] = '{9,  96'h028B020020CB030041,   1'b1, 1'b0, 2, 64'h8B020020CB030041};
    vecs[4] = '{5,  96'h0112345678,           1'b1, 1'b0, 1, 64'h12345678};
`endif
    vecs[2] = '{1,  96'h00, 1'b0, 1'b1, 0, 64'h0};
    vecs[3] = '{1,  96'h11, 1'b0, 1'b1, 0, 64'h0};
    vecs[5] = '{1,  96'hFF, 1'b0, 1'b1, 0, 64'h0};

    // Reset state, then byte_ready rises on the first edge with RST high.
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_rst", 32'(byte_ready), 32'd1);
    check("cpu_rst_after_rst", 32'(cpu_rst), 32'd1);

    // Table of complete load scenarios.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].nw; k++)
        exp_q.push_back({AW'(4 * k), vecs[v].words[32 * (vecs[v].nw - 1 - k) +: 32]});
      for (int i = 0; i < vecs[v].nb; i++)
        send_byte(vecs[v].bytes[8 * (vecs[v].nb - 1 - i) +: 8]);
      wait_end();
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_cpu_rst", v), 32'(cpu_rst), 32'(!vecs[v].exp_done));
      check($sformatf("v%0d_ready", v), 32'(byte_ready), 32'd0);
      check($sformatf("v%0d_writes_seen", v), 32'(exp_q.size()), 32'd0);
      do_reload();
    end

    // Gapped stream with a reload pulse mid-load that must be ignored.
    exp_q.push_back({AW'(0), 32'h8B020020});
    send_byte(8'h01);
    idle_cycle();
    send_byte(8'h8B);
    reload = 1'b1;
    idle_cycle();
    reload = 1'b0;
    check("reload_ignored_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h02);
    idle_cycle();
    send_byte(8'h00);
    idle_cycle();
    send_byte(8'h20);
    check("gap_write_latency", 32'(im_we), 32'd1);
    check("gap_write_ready", 32'(byte_ready), 32'd0);
`ifdef OLIVIA_LOADER_CSUM_EN
    idle_cycle();
    check("gap_ready_after_write", 32'(byte_ready), 32'd1);
    check("gap_we_after_write", 32'(im_we), 32'd0);
    idle_cycle();
    send_byte(8'hA9);
`endif
    wait_end();
    check("gap_done", 32'(done), 32'd1);
    check("gap_cpu_rst", 32'(cpu_rst), 32'd0);
    check("gap_writes_seen", 32'(exp_q.size()), 32'd0);
    do_reload();

    // Full-depth image: N = DEPTH_WORDS, addresses up to 60.
    begin
      logic [31:0] w;
      logic [7:0]  cs;
      cs = 8'd0;
      send_byte(8'h10);
      for (int i = 0; i < 16; i++) begin
        w = {8'(i), 8'hC3 ^ 8'(i), 8'h5A, 8'(i * 7)};
        exp_q.push_back({AW'(4 * i), w});
        for (int j = 3; j >= 0; j--) begin
          cs = cs ^ w[8 * j +: 8];
          send_byte(w[8 * j +: 8]);
        end
      end
`ifdef OLIVIA_LOADER_CSUM_EN
      send_byte(cs);
`endif
      wait_end();
      check("full_done", 32'(done), 32'd1);
      check("full_err", 32'(err), 32'd0);
      check("full_writes_seen", 32'(exp_q.size()), 32'd0);
    end
    do_reload();

    // Reset after two payload bytes: the partial word must be discarded.
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hEE);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check_reset_outputs("midrst");
    RST = 1'b1;
    @(posedge CLK);
    #1;
    exp_q.push_back({AW'(0), 32'h8B020020});
    send_byte(8'h01);
    send_byte(8'h8B);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h20);
`ifdef OLIVIA_LOADER_CSUM_EN
    send_byte(8'hA9);
`endif
    wait_end();
    check("restream_done", 32'(done), 32'd1);
    check("restream_err", 32'(err), 32'd0);
    check("restream_writes_seen", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
